seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display. It shares a single segdecoder instance among DIGITS digits: it drives the decoder's 4-bit input with the current digit's nibble and gates the decoder's segment output onto the shared segment bus. It also generates active-low digit enables, with a ghosting-guard blank interval at the start of each digit slot. Display data is written through a shadow register and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 50000, clock cycles per digit slot (>= BLANK_CYC+1)
BLANK_CYC, 500, cycles at slot start with all digits off (>= 1)
DIV_W, 16, width of the slot cycle counter (2^DIV_W >= CLK_DIV)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write strobe for new display value, single cycle
wr_data  in  4*DIGITS  BCD/hex nibbles, [3:0] = digit 0 (least significant, rightmost)
blank_lz  in  1  1 = blank leading zeros
dp_in  in  DIGITS  decimal point per digit, 1 = lit
dec_data  out  4  nibble to the shared segdecoder
seg_in  in  7  segment pattern returned by segdecoder (active-low)
seg_out  out  7  segment bus to the display (active-low)
dp_out  out  1  decimal point to the display (active-low)
an  out  DIGITS  digit enables (active-low, one-hot-low or all high)
pending  out  1  a written value is waiting for commit
upd_done  out  1  one-cycle pulse, data committed to the display register

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on the rising edge of clk. Reset has priority over all other inputs.
- Reset state: div_cnt=0, idx=0, disp_reg=0, pend_reg=0, pending=0, upd_done=0, FSM=BLANK. Resulting outputs: an=all 1, seg_out=7'h7F, dp_out=1, dec_data=0.
- div_cnt counts 0..CLK_DIV-1 and wraps to 0. idx advances (idx+1) mod DIGITS on the cycle div_cnt wraps.
- FSM has two states, derived from div_cnt:
  - BLANK while div_cnt < BLANK_CYC.
  - SHOW while div_cnt >= BLANK_CYC.
- BLANK outputs: an=all 1, seg_out=7'h7F, dp_out=1.
- SHOW outputs: an[idx]=0 and all other an bits =1; seg_out=seg_in unless the digit is blanked; dp_out=~dp_in[idx].
- dec_data = disp_reg[4*idx +: 4] in both states. The decoder is combinational, so the display sees no added latency. an, seg_out and dp_out are decoded from registered state only, with no added register stage.
- Leading-zero blank: when blank_lz=1, idx>0 and every nibble idx..DIGITS-1 of disp_reg is 0, then seg_out=7'h7F. dp still follows dp_in. Digit 0 is never blanked.
- Frame end is the cycle where div_cnt=CLK_DIV-1 and idx=DIGITS-1.
- Write outside frame end: pend_reg<=wr_data and pending<=1. Back-to-back writes follow last-write-wins.
- At frame end, if wr_en=1: disp_reg<=wr_data (the new write wins over pend_reg), pending<=0, and upd_done=1 on the next cycle.
- At frame end, if wr_en=0 and pending=1: disp_reg<=pend_reg, pending<=0, and upd_done=1 on the next cycle.
- At frame end, if neither applies: no change, upd_done=0.
- Commit latency: a write becomes visible at the start of the next frame (idx=0). Maximum delay is DIGITS*CLK_DIV cycles.
- upd_done is high for exactly one cycle per commit and is never high in consecutive cycles.
- Reset asserted mid-slot or mid-frame: all state is restored to reset values on the next edge, and pending writes are discarded.

Test Plan:
(Bench parameters: DIGITS=4, CLK_DIV=8, BLANK_CYC=2, DIV_W=3; stub segdecoder connected.)
- Reset then release -> an=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles; seg_out=7'h7F during reset and blank; dec_data=0; upd_done=0.
- Free run 32 cycles after reset -> an low phases 1110, 1101, 1011, 0111, each 6 cycles preceded by 2 cycles of 1111; frame repeats every 32 cycles.
- wr_en with wr_data=16'h1234 at cycle 5 of the frame -> pending=1 and display unchanged until frame end; then a single upd_done pulse; next frame dec_data=4,3,2,1 for idx 0..3.
- blank_lz=1, committed value 16'h0050 -> digits 3 and 2 give seg_out=7'h7F; digit 1 gives seg_out=seg_in for 5; digit 0 gives seg_in for 0. With blank_lz=0, all four digits pass seg_in.
- pending holds 16'hAAAA and wr_en with 16'h5555 occurs on the frame-end cycle -> disp_reg=16'h5555, pending=0, one upd_done pulse.
- rst_n=0 for one cycle mid-SHOW of idx=2 with pending=1 -> next cycle an=4'b1111, pending=0, disp_reg=0, and the scan restarts at idx 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// seg_scan_ctrl: multiplexed 7-segment scan controller sharing one segment decoder.
// Rev 1.0 - initial release.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500,
  parameter int DIV_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            dec_data,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  upd_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pending_q, pending_d;
  logic                upd_done_q, upd_done_d;
  state_t              state_q, state_d;

  logic                slot_end;
  logic                idx_last;
  logic                frame_end;
  logic [DIGITS-1:0]   upper_zero;
  logic                blank_digit;

  assign slot_end  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign idx_last  = (idx_q == IDX_W'(DIGITS - 1));
  assign frame_end = slot_end && idx_last;

  // upper_zero[i]: nibbles i..DIGITS-1 of the display register are all zero
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign upper_zero[i] = (disp_q[4*DIGITS-1:4*i] == '0);
  end

  assign blank_digit = blank_lz && (idx_q != '0) && upper_zero[idx_q];

  always_comb begin
    div_cnt_d  = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pending_d  = pending_q;
    upd_done_d = 1'b0;

    if (slot_end) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end

    // A write landing on the frame-end cycle goes straight to the display
    if (frame_end) begin
      if (wr_en) begin
        disp_d     = wr_data;
        pending_d  = 1'b0;
        upd_done_d = 1'b1;
      end else if (pending_q) begin
        disp_d     = pend_q;
        pending_d  = 1'b0;
        upd_done_d = 1'b1;
      end
    end else if (wr_en) begin
      pend_d    = wr_data;
      pending_d = 1'b1;
    end

    state_d = (div_cnt_d < DIV_W'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pending_q  <= 1'b0;
      upd_done_q <= 1'b0;
      state_q    <= ST_BLANK;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pending_q  <= pending_d;
      upd_done_q <= upd_done_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    an       = '1;
    seg_out  = 7'h7F;
    dp_out   = 1'b1;
    dec_data = disp_q[{idx_q, 2'b00} +: 4];
    if (state_q == ST_SHOW) begin
      an      = ~(DIGITS'(1) << idx_q);
      seg_out = blank_digit ? 7'h7F : seg_in;
      dp_out  = ~dp_in[idx_q];
    end
  end

  assign pending  = pending_q;
  assign upd_done = upd_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// tb_seg_scan_ctrl: scoreboard bench; a timing model of the scan pushes expected outputs per cycle.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  dec_data;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an;
  logic        pending;
  logic        upd_done;

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  // Stub segment decoder
  assign seg_in = hex7(dec_data);

  seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .blank_lz(blank_lz), .dp_in(dp_in), .dec_data(dec_data), .seg_in(seg_in),
    .seg_out(seg_out), .dp_out(dp_out), .an(an), .pending(pending), .upd_done(upd_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dec;
    logic       pend;
    logic       upd;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: c = position in the 32-cycle frame, fr = frame number
  int          c = 0;
  int          fr = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pending = 1'b0;
  logic        m_upd = 1'b0;

  task automatic model_advance();
    if (!rst_n) begin
      c = 0; m_disp = '0; m_pend = '0; m_pending = 1'b0; m_upd = 1'b0;
      if (fr != 0) fr = fr + 1;
    end else begin
      m_upd = 1'b0;
      if (c == 31) begin
        if (wr_en) begin
          m_disp = wr_data; m_pending = 1'b0; m_upd = 1'b1;
        end else if (m_pending) begin
          m_disp = m_pend; m_pending = 1'b0; m_upd = 1'b1;
        end
      end else if (wr_en) begin
        m_pend = wr_data; m_pending = 1'b1;
      end
      c = (c + 1) % 32;
      if (c == 0) fr = fr + 1;
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int   idx = c / 8;
    int   div = c % 8;
    logic lz;
    o.dec  = 4'((m_disp >> (4 * idx)) & 16'hF);
    lz     = blank_lz && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
    o.an   = (div < 2) ? 4'b1111 : ~(4'b0001 << idx);
    o.seg  = (div < 2 || lz) ? 7'h7F : hex7(o.dec);
    o.dp   = (div < 2) ? 1'b1 : ~dp_in[idx];
    o.pend = m_pending;
    o.upd  = m_upd;
    return o;
  endfunction

  // Monitor: compares every presented cycle against the scoreboard head
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{an: an, seg: seg_out, dp: dp_out, dec: dec_data, pend: pending, upd: upd_done};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cyc%0d an/seg/dp/dec/pend/upd actual=%b/%h/%b/%h/%b/%b expected=%b/%h/%b/%h/%b/%b",
                 cyc, a.an, a.seg, a.dp, a.dec, a.pend, a.upd, e.an, e.seg, e.dp, e.dec, e.pend, e.upd);
      end
    end
  end

  initial begin
    for (int k = 0; k < 400 && fr < 9; k++) begin
      @(posedge clk);
      model_advance();
      #1;
      cyc = k;
      rst_n    = !(k < 3 || (fr == 6 && c == 20));
      wr_en    = 1'b0;
      wr_data  = '0;
      blank_lz = (fr == 3 || fr == 4);
      dp_in    = (fr == 2) ? 4'b0101 : (fr == 4) ? 4'b1010 : 4'b0000;
      if (rst_n) begin
        if (fr == 1 && c == 5)  begin wr_en = 1'b1; wr_data = 16'h1234; end
        if (fr == 2 && c == 10) begin wr_en = 1'b1; wr_data = 16'h0050; end
        if (fr == 5 && c == 7)  begin wr_en = 1'b1; wr_data = 16'hAAAA; end
        if (fr == 5 && c == 31) begin wr_en = 1'b1; wr_data = 16'h5555; end
        if (fr == 6 && c == 3)  begin wr_en = 1'b1; wr_data = 16'h0009; end
      end
      exp_q.push_back(model_out());
    end
    @(posedge clk);
    #1;
    if (fr < 9) begin
      miscompares++;
      $display("FAIL run_length actual_frames=%0d required=9", fr);
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain actual_left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
